// File: rtl/rv32i_types.sv
// Shared RV32I types: data-memory responder states and load/store funct3 codes.
// Alignment helper used when DMEM_ALIGN_CHECK_EN is defined.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } dmem_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Reserved widths count as word accesses.
  function automatic logic is_misaligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    case (f3)
      F3_LB, F3_LBU: return 1'b0;
      F3_LH, F3_LHU: return off[0];
      default:       return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_format.sv
// Load lane select and sign/zero extension for the data-memory responder.
// Combinational; reserved funct3 values return the raw word.
module dmem_load_format
  import rv32i_types::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] raw,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign shifted = raw >> {offset, 3'b000};
  assign byte_v  = shifted[7:0];
  assign half_v  = offset[1] ? raw[31:16] : raw[15:0];

  always_comb begin
    data = raw;
    case (funct3)
      F3_LB:   data = {{24{byte_v[7]}}, byte_v};
      F3_LBU:  data = {24'h0, byte_v};
      F3_LH:   data = {{16{half_v[15]}}, half_v};
      F3_LHU:  data = {16'h0, half_v};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: IDLE/ACCESS/RESP handshake to a word-wide memory.
// DMEM_ALIGN_CHECK_EN defined: misaligned halfword/word requests fault without access.
module dmem_responder
  import rv32i_types::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [2:0]  funct3,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        stall,
  output logic        bus_error,
  output logic        misaligned,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output logic [31:0] pmem_wdata,
  output logic [3:0]  pmem_byte_enable,
  input  logic [31:0] pmem_rdata,
  input  logic        pmem_resp
);

  dmem_state_t state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  f3_q;
  logic        wr_q;
  logic [15:0] cnt;
  logic [31:0] load_data;
  logic        req;
  logic        mis_now;

  assign req = mem_read | mem_write;

`ifdef DMEM_ALIGN_CHECK_EN
  assign mis_now = is_misaligned(funct3, mem_addr[1:0]);
`else
  assign mis_now = 1'b0;
`endif

  dmem_load_format u_fmt (
    .funct3 (f3_q),
    .offset (addr_q[1:0]),
    .raw    (pmem_rdata),
    .data   (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      f3_q       <= '0;
      wr_q       <= 1'b0;
      cnt        <= '0;
      mem_rdata  <= '0;
      mem_resp   <= 1'b0;
      bus_error  <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req) begin
          addr_q  <= mem_addr;
          wdata_q <= mem_wdata;
          f3_q    <= funct3;
          wr_q    <= mem_write;
          cnt     <= '0;
          if (mis_now) begin
            state      <= RESP;
            mem_resp   <= 1'b1;
            misaligned <= 1'b1;
            mem_rdata  <= '0;
          end else begin
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (pmem_resp) begin
            state     <= RESP;
            mem_resp  <= 1'b1;
            mem_rdata <= wr_q ? 32'h0 : load_data;
          end else if (cnt == 16'(MAX_WAIT - 1)) begin
            // Final allowed cycle elapsed with no answer.
            state     <= RESP;
            mem_resp  <= 1'b1;
            bus_error <= 1'b1;
            mem_rdata <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RESP: begin
          state      <= IDLE;
          mem_resp   <= 1'b0;
          bus_error  <= 1'b0;
          misaligned <= 1'b0;
          mem_rdata  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stall = (state == ACCESS) || (state == IDLE && req);

  always_comb begin
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    pmem_address     = '0;
    pmem_wdata       = '0;
    pmem_byte_enable = '0;
    if (state == ACCESS) begin
      pmem_read    = !wr_q;
      pmem_write   = wr_q;
      pmem_address = {addr_q[31:2], 2'b00};
      if (wr_q) begin
        case (f3_q)
          F3_SB: begin
            pmem_byte_enable = 4'b0001 << addr_q[1:0];
            pmem_wdata       = {4{wdata_q[7:0]}};
          end
          F3_SH: begin
            pmem_byte_enable = addr_q[1] ? 4'b1100 : 4'b0011;
            pmem_wdata       = {2{wdata_q[15:0]}};
          end
          default: begin
            pmem_byte_enable = 4'b1111;
            pmem_wdata       = wdata_q;
          end
        endcase
      end else begin
        pmem_byte_enable = 4'b1111;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (MAX_WAIT=4).
// Randomized traffic is checked against an arithmetic reference model.
module tb_dmem_responder;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  funct3;
  logic [31:0] mem_rdata;
  logic        mem_resp, stall, bus_error, misaligned;
  logic        pmem_read, pmem_write;
  logic [31:0] pmem_address, pmem_wdata;
  logic [3:0]  pmem_byte_enable;
  logic [31:0] pmem_rdata;
  logic        pmem_resp;

  int n_tests = 0;
  int n_fail  = 0;

  int          o_lat, o_strobes;
  logic [31:0] o_addr, o_wd, o_rdata;
  logic [3:0]  o_be;
  logic        o_rd, o_wr, o_stable, o_err, o_mis;
  logic        o_stall_req, o_stall_acc, o_stall_resp;

  dmem_responder #(.MAX_WAIT(MW)) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .funct3           (funct3),
    .mem_rdata        (mem_rdata),
    .mem_resp         (mem_resp),
    .stall            (stall),
    .bus_error        (bus_error),
    .misaligned       (misaligned),
    .pmem_read        (pmem_read),
    .pmem_write       (pmem_write),
    .pmem_address     (pmem_address),
    .pmem_wdata       (pmem_wdata),
    .pmem_byte_enable (pmem_byte_enable),
    .pmem_rdata       (pmem_rdata),
    .pmem_resp        (pmem_resp)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_load(
    input logic [2:0] f3, input logic [1:0] off, input logic [31:0] raw
  );
    logic [31:0] b, h;
    b = (raw >> (8 * off)) & 32'hFF;
    h = (raw >> (16 * off[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return b[7] ? (b | 32'hFFFFFF00) : b;
      3'd4:    return b;
      3'd1:    return h[15] ? (h | 32'hFFFF0000) : h;
      3'd5:    return h;
      default: return raw;
    endcase
  endfunction

  function automatic logic [3:0] model_be(
    input logic wr, input logic [2:0] f3, input logic [1:0] off
  );
    if (!wr) return 4'hF;
    if (f3 == 3'd0) return 4'(1 << off);
    if (f3 == 3'd1) return off[1] ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wd(
    input logic [2:0] f3, input logic [31:0] wd
  );
    if (f3 == 3'd0) return 32'h01010101 * {24'h0, wd[7:0]};
    if (f3 == 3'd1) return 32'h00010001 * {16'h0, wd[15:0]};
    return wd;
  endfunction

  function automatic logic model_mis(
    input logic [2:0] f3, input logic [1:0] off
  );
`ifdef DMEM_ALIGN_CHECK_EN
    if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
    if (f3 == 3'd1 || f3 == 3'd5) return off[0];
    return off != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  // Drives one request and plays the memory; delay<0 means never answer.
  task automatic run_access(
    input logic wr, input logic [31:0] a, input logic [31:0] wd,
    input logic [2:0] f3, input int delay, input logic [31:0] raw
  );
    @(negedge clk);
    mem_read = !wr; mem_write = wr;
    mem_addr = a; mem_wdata = wd; funct3 = f3;
    #1 o_stall_req = stall;
    o_lat = -1; o_strobes = 0; o_stable = 1'b1; o_stall_acc = 1'b1;
    o_addr = '0; o_wd = '0; o_be = '0; o_rd = 1'b0; o_wr = 1'b0;
    o_rdata = '0; o_err = 1'b0; o_mis = 1'b0; o_stall_resp = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b0;
      mem_addr = $urandom; mem_wdata = $urandom; funct3 = 3'($urandom);
      pmem_resp = 1'b0;
      #1;
      if (mem_resp) begin
        o_lat = cyc; o_rdata = mem_rdata; o_err = bus_error;
        o_mis = misaligned; o_stall_resp = stall;
        break;
      end
      if (pmem_read || pmem_write) begin
        if (o_strobes == 0) begin
          o_addr = pmem_address; o_wd = pmem_wdata; o_be = pmem_byte_enable;
          o_rd = pmem_read; o_wr = pmem_write;
        end else if ({o_addr, o_wd, o_be, o_rd, o_wr} !==
                     {pmem_address, pmem_wdata, pmem_byte_enable,
                      pmem_read, pmem_write}) begin
          o_stable = 1'b0;
        end
        o_strobes++;
      end
      if (!stall) o_stall_acc = 1'b0;
      if (delay >= 0 && cyc == delay + 1) begin
        pmem_resp = 1'b1; pmem_rdata = raw;
      end else begin
        pmem_rdata = $urandom;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({mem_rdata, mem_resp, stall, bus_error, misaligned, pmem_read,
         pmem_write, pmem_address, pmem_wdata, pmem_byte_enable} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got rdata=%h resp=%b stall=%b pr=%b pw=%b want all 0",
               mem_rdata, mem_resp, stall, pmem_read, pmem_write);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store_word;
    run_access(1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 2, 32'h0);
    n_tests++;
    if (o_lat !== 4) begin
      n_fail++; $display("FAIL sw_latency got %0d want 4", o_lat);
    end
    n_tests++;
    if ({o_be, o_addr, o_wd} !== {4'hF, 32'h100, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL sw_bus got be=%h addr=%h wd=%h want be=f addr=00000100 wd=deadbeef",
               o_be, o_addr, o_wd);
    end
    n_tests++;
    if ({o_wr, o_rd, o_strobes[7:0], o_stable} !== {1'b1, 1'b0, 8'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL sw_strobe got wr=%b rd=%b n=%0d stable=%b want 1 0 3 1",
               o_wr, o_rd, o_strobes, o_stable);
    end
    n_tests++;
    if ({o_stall_req, o_stall_acc, o_stall_resp, o_err} !== 4'b1100) begin
      n_fail++;
      $display("FAIL sw_stall got req=%b acc=%b resp=%b err=%b want 1 1 0 0",
               o_stall_req, o_stall_acc, o_stall_resp, o_err);
    end
  endtask

  task automatic test_load_byte;
    run_access(1'b0, 32'h203, 32'h0, 3'b000, 0, 32'h80FF0000);
    n_tests++;
    if ({o_lat[7:0], o_rdata} !== {8'd2, 32'hFFFFFF80}) begin
      n_fail++; $display("FAIL lb got lat=%0d data=%h want 2 ffffff80", o_lat, o_rdata);
    end
    n_tests++;
    if ({o_rd, o_be, o_addr} !== {1'b1, 4'hF, 32'h200}) begin
      n_fail++;
      $display("FAIL lb_bus got rd=%b be=%h addr=%h want 1 f 00000200", o_rd, o_be, o_addr);
    end
    run_access(1'b0, 32'h203, 32'h0, 3'b100, 0, 32'h80FF0000);
    n_tests++;
    if (o_rdata !== 32'h00000080) begin
      n_fail++; $display("FAIL lbu got %h want 00000080", o_rdata);
    end
  endtask

  task automatic test_halfword;
    run_access(1'b1, 32'h302, 32'hFFFF1234, 3'b001, 1, 32'h0);
    n_tests++;
    if ({o_be, o_wd, o_addr} !== {4'hC, 32'h12341234, 32'h300}) begin
      n_fail++;
      $display("FAIL sh got be=%h wd=%h addr=%h want c 12341234 00000300", o_be, o_wd, o_addr);
    end
    run_access(1'b0, 32'h302, 32'h0, 3'b101, 0, 32'hABCD0000);
    n_tests++;
    if (o_rdata !== 32'h0000ABCD) begin
      n_fail++; $display("FAIL lhu got %h want 0000abcd", o_rdata);
    end
    run_access(1'b0, 32'h302, 32'h0, 3'b001, 0, 32'hABCD0000);
    n_tests++;
    if (o_rdata !== 32'hFFFFABCD) begin
      n_fail++; $display("FAIL lh got %h want ffffabcd", o_rdata);
    end
  endtask

  task automatic test_timeout;
    run_access(1'b0, 32'h500, 32'h0, 3'b010, -1, 32'h0);
    n_tests++;
    if ({o_lat[7:0], o_strobes[7:0]} !== {8'(MW + 1), 8'(MW)}) begin
      n_fail++;
      $display("FAIL timeout_len got lat=%0d strobes=%0d want %0d %0d",
               o_lat, o_strobes, MW + 1, MW);
    end
    n_tests++;
    if ({o_err, o_rdata, o_stall_acc} !== {1'b1, 32'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL timeout_err got err=%b data=%h stall=%b want 1 0 1",
               o_err, o_rdata, o_stall_acc);
    end
    // Answer arriving on the last allowed cycle still completes normally.
    run_access(1'b0, 32'h504, 32'h0, 3'b010, MW - 1, 32'h13579BDF);
    n_tests++;
    if ({o_lat[7:0], o_err, o_rdata} !== {8'(MW + 1), 1'b0, 32'h13579BDF}) begin
      n_fail++;
      $display("FAIL late_resp got lat=%0d err=%b data=%h want %0d 0 13579bdf",
               o_lat, o_err, o_rdata, MW + 1);
    end
  endtask

  task automatic test_alignment;
`ifdef DMEM_ALIGN_CHECK_EN
    run_access(1'b0, 32'h401, 32'h0, 3'b010, 0, 32'h11223344);
    n_tests++;
    if ({o_lat[7:0], o_strobes[7:0], o_mis, o_rdata} !== {8'd1, 8'd0, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL misalign_lw got lat=%0d strobes=%0d mis=%b data=%h want 1 0 1 0",
               o_lat, o_strobes, o_mis, o_rdata);
    end
    run_access(1'b1, 32'h403, 32'h55, 3'b001, 0, 32'h0);
    n_tests++;
    if ({o_strobes[7:0], o_mis} !== {8'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL misalign_sh got strobes=%0d mis=%b want 0 1", o_strobes, o_mis);
    end
`else
    run_access(1'b0, 32'h401, 32'h0, 3'b010, 0, 32'h11223344);
    n_tests++;
    if ({o_mis, o_addr, o_rdata} !== {1'b0, 32'h400, 32'h11223344}) begin
      n_fail++;
      $display("FAIL unaligned_lw got mis=%b addr=%h data=%h want 0 00000400 11223344",
               o_mis, o_addr, o_rdata);
    end
    run_access(1'b0, 32'h403, 32'h0, 3'b001, 0, 32'h80010000);
    n_tests++;
    if ({o_mis, o_rdata} !== {1'b0, 32'hFFFF8001}) begin
      n_fail++;
      $display("FAIL unaligned_lh got mis=%b data=%h want 0 ffff8001", o_mis, o_rdata);
    end
`endif
  endtask

  task automatic test_reset_mid_access;
    logic seen;
    @(negedge clk);
    mem_read = 1'b1; mem_addr = 32'h600; funct3 = 3'b010;
    @(negedge clk);
    mem_read = 1'b0;
    #1;
    n_tests++;
    if (pmem_read !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre got pmem_read=%b want 1", pmem_read);
    end
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if ({pmem_read, pmem_write, pmem_byte_enable, stall} !== 7'b0) begin
      n_fail++;
      $display("FAIL rst_drop got pr=%b pw=%b be=%h stall=%b want 0",
               pmem_read, pmem_write, pmem_byte_enable, stall);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (mem_resp || pmem_read) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL rst_no_resp got activity=%b want 0", seen);
    end
  endtask

  task automatic test_random;
    logic        wr, mis, err;
    logic [31:0] a, wd, raw, exp_rd;
    logic [2:0]  f3;
    int          d, exp_lat, exp_n;
    logic [3:0]  exp_be;
    for (int i = 0; i < 60; i++) begin
      wr  = 1'($urandom);
      a   = $urandom;
      wd  = $urandom;
      raw = $urandom;
      f3  = wr ? 3'($urandom_range(0, 2)) : 3'($urandom);
      d   = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3));
      mis = model_mis(f3, a[1:0]);
      err = !mis && d < 0;
      run_access(wr, a, wd, f3, d, raw);
      if (mis) begin
        exp_lat = 1; exp_n = 0; exp_be = 4'h0; exp_rd = 32'h0;
      end else begin
        exp_lat = err ? MW + 1 : d + 2;
        exp_n   = err ? MW : d + 1;
        exp_be  = model_be(wr, f3, a[1:0]);
        exp_rd  = (wr || err) ? 32'h0 : model_load(f3, a[1:0], raw);
      end
      n_tests++;
      if ({o_lat[7:0], o_strobes[7:0], o_be, o_addr, (o_wr ? o_wd : 32'h0),
           (wr ? 32'h0 : o_rdata), o_err, o_mis, o_rd, o_wr, o_stable} !==
          {8'(exp_lat), 8'(exp_n), exp_be,
           (mis ? 32'h0 : {a[31:2], 2'b00}),
           ((wr && !mis) ? model_wd(f3, wd) : 32'h0),
           exp_rd, err, mis, !wr && !mis, wr && !mis, 1'b1}) begin
        n_fail++;
        $display("FAIL random[%0d] wr=%b f3=%0d a=%h d=%0d got lat=%0d n=%0d be=%h addr=%h wd=%h rd=%h err=%b mis=%b want lat=%0d n=%0d be=%h rd=%h err=%b mis=%b",
                 i, wr, f3, a, d, o_lat, o_strobes, o_be, o_addr, o_wd,
                 o_rdata, o_err, o_mis, exp_lat, exp_n, exp_be, exp_rd, err, mis);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0;
    mem_addr = '0; mem_wdata = '0; funct3 = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    test_reset();
    test_store_word();
    test_load_byte();
    test_halfword();
    test_timeout();
    test_alignment();
    test_reset_mid_access();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
